// File: rtl/silife_max7219.sv
// silife_max7219: snapshots the cell matrix on a frame request and streams it,
// one row per 16-bit word, to a MAX7219 LED driver over CS/SCK/MOSI.
// The first frame after reset is preceded by the driver configuration words.
module silife_max7219 #(
  parameter int WIDTH   = 8,
  parameter int HEIGHT  = 8,
  parameter int CLK_DIV = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      frame,
  input  logic [3:0]                brightness,
  input  logic [WIDTH*HEIGHT-1:0]   cells,
  output logic                      busy,
  output logic                      frame_done,
  output logic                      spi_cs,
  output logic                      spi_sck,
  output logic                      spi_mosi
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  // Word loading and frame completion happen on the state transitions
  // (IDLE->LOW, GAP->LOW, GAP->IDLE), so no cycle is spent outside the
  // LOW/HIGH/GAP phases and a word takes exactly 33*CLK_DIV cycles.
  typedef enum logic [1:0] {
    S_IDLE,
    S_LOW,
    S_HIGH,
    S_GAP
  } state_t;

  state_t                    state_q, state_d;
  logic [WIDTH*HEIGHT-1:0]   cells_q, cells_d;
  logic [3:0]                bright_q, bright_d;
  logic [3:0]                word_idx_q, word_idx_d;
  logic [3:0]                bit_cnt_q, bit_cnt_d;
  logic [DIV_W-1:0]          div_q, div_d;
  logic [15:0]               shift_q, shift_d;
  logic                      cs_q, cs_d;
  logic                      sck_q, sck_d;
  logic                      mosi_q, mosi_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      init_done_q, init_done_d;

  // Word source: live inputs at the accepting cycle, shadow copy afterwards.
  logic [WIDTH*HEIGHT-1:0]   src_cells;
  logic [3:0]                src_bright;
  logic [7:0]                rows [8];
  logic [3:0]                load_idx;
  logic [3:0]                eff_idx;
  logic [3:0]                row_sel;
  logic [3:0]                last_idx;
  logic [15:0]               load_word;
  logic                      div_end;

  assign src_cells  = (state_q == S_IDLE) ? cells : cells_q;
  assign src_bright = (state_q == S_IDLE) ? brightness : bright_q;

  // Row bytes: cell x drives data bit 7-x; unused digit rows read as zero.
  genvar gi, gx;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_row
      if (gi < HEIGHT) begin : g_used
        for (gx = 0; gx < 8; gx++) begin : g_bit
          assign rows[gi][7-gx] = src_cells[gi*WIDTH+gx];
        end
      end else begin : g_unused
        assign rows[gi] = 8'h00;
      end
    end
  endgenerate

  assign div_end  = (div_q == DIV_LAST);
  assign last_idx = init_done_q ? 4'(HEIGHT) : 4'(HEIGHT + 4);
  assign load_idx = (state_q == S_IDLE) ? 4'd0 : word_idx_q + 4'd1;
  // Once configured, skip the four configuration slots of the word list.
  assign eff_idx  = load_idx + (init_done_q ? 4'd4 : 4'd0);
  assign row_sel  = eff_idx - 4'd5;

  // Select the 16-bit word for the slot about to be transmitted.
  always_comb begin
    load_word = 16'h0000;
    case (eff_idx)
      4'd0:    load_word = 16'h0C01;
      4'd1:    load_word = {8'h0B, 8'(HEIGHT - 1)};
      4'd2:    load_word = 16'h0900;
      4'd3:    load_word = 16'h0F00;
      4'd4:    load_word = {8'h0A, 4'h0, src_bright};
      default: load_word = {8'h01 + {5'b0, row_sel[2:0]}, rows[row_sel[2:0]]};
    endcase
  end

  // Next-state logic for the serializer FSM and all registered outputs.
  always_comb begin
    state_d     = state_q;
    cells_d     = cells_q;
    bright_d    = bright_q;
    word_idx_d  = word_idx_q;
    bit_cnt_d   = bit_cnt_q;
    div_d       = div_q;
    shift_d     = shift_q;
    cs_d        = cs_q;
    sck_d       = sck_q;
    mosi_d      = mosi_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    init_done_d = init_done_q;
    case (state_q)
      S_IDLE: begin
        if (frame) begin
          cells_d    = cells;
          bright_d   = brightness;
          word_idx_d = 4'd0;
          shift_d    = load_word;
          mosi_d     = load_word[15];
          cs_d       = 1'b0;
          sck_d      = 1'b0;
          bit_cnt_d  = 4'd15;
          div_d      = '0;
          busy_d     = 1'b1;
          state_d    = S_LOW;
        end
      end
      S_LOW: begin
        if (div_end) begin
          div_d   = '0;
          sck_d   = 1'b1;
          state_d = S_HIGH;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_HIGH: begin
        if (div_end) begin
          div_d = '0;
          sck_d = 1'b0;
          if (bit_cnt_q == 4'd0) begin
            cs_d    = 1'b1;
            mosi_d  = 1'b0;
            state_d = S_GAP;
          end else begin
            bit_cnt_d = bit_cnt_q - 4'd1;
            shift_d   = {shift_q[14:0], 1'b0};
            mosi_d    = shift_q[14];
            state_d   = S_LOW;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_GAP: begin
        if (div_end) begin
          div_d = '0;
          if (word_idx_q == last_idx) begin
            done_d      = 1'b1;
            busy_d      = 1'b0;
            init_done_d = 1'b1;
            state_d     = S_IDLE;
          end else begin
            word_idx_d = word_idx_q + 4'd1;
            shift_d    = load_word;
            mosi_d     = load_word[15];
            cs_d       = 1'b0;
            bit_cnt_d  = 4'd15;
            state_d    = S_LOW;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register; reset drops any transfer in flight and forces the link idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cells_q     <= '0;
      bright_q    <= 4'h0;
      word_idx_q  <= 4'd0;
      bit_cnt_q   <= 4'd0;
      div_q       <= '0;
      shift_q     <= 16'h0000;
      cs_q        <= 1'b1;
      sck_q       <= 1'b0;
      mosi_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cells_q     <= cells_d;
      bright_q    <= bright_d;
      word_idx_q  <= word_idx_d;
      bit_cnt_q   <= bit_cnt_d;
      div_q       <= div_d;
      shift_q     <= shift_d;
      cs_q        <= cs_d;
      sck_q       <= sck_d;
      mosi_q      <= mosi_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      init_done_q <= init_done_d;
    end
  end

  assign busy       = busy_q;
  assign frame_done = done_q;
  assign spi_cs     = cs_q;
  assign spi_sck    = sck_q;
  assign spi_mosi   = mosi_q;

endmodule

// File: tb/tb_silife_max7219.sv
// Directed bench for silife_max7219: an 8x8/CLK_DIV=4 instance and a
// 4-row/CLK_DIV=1 instance, each watched by an SPI decoder and protocol checker.
module tb_silife_max7219;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_a, frame_b;
  logic [3:0]  bright_a, bright_b;
  logic [63:0] cells_a;
  logic [31:0] cells_b;
  logic        busy_a, done_a, cs_a, sck_a, mosi_a;
  logic        busy_b, done_b, cs_b, sck_b, mosi_b;

  int checks   = 0;
  int failures = 0;

  logic [15:0] words_a[$];
  logic [15:0] words_b[$];
  logic [15:0] exp_q[$];
  int          viol[2];

  always #5 clk = ~clk;

  silife_max7219 #(.WIDTH(8), .HEIGHT(8), .CLK_DIV(4)) dut_a (
    .clk(clk), .reset(rst), .frame(frame_a), .brightness(bright_a), .cells(cells_a),
    .busy(busy_a), .frame_done(done_a), .spi_cs(cs_a), .spi_sck(sck_a), .spi_mosi(mosi_a)
  );

  silife_max7219 #(.WIDTH(8), .HEIGHT(4), .CLK_DIV(1)) dut_b (
    .clk(clk), .reset(rst), .frame(frame_b), .brightness(bright_b), .cells(cells_b),
    .busy(busy_b), .frame_done(done_b), .spi_cs(cs_b), .spi_sck(sck_b), .spi_mosi(mosi_b)
  );

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // SPI decoder and protocol checker for both instances, sampled on the falling edge.
  initial begin
    logic        pcs[2], psck[2], pmosi[2];
    logic [15:0] sh[2];
    int          nbits[2], last_rise[2], hi_run[2], div[2];
    int          cyc;
    logic        c, s, d;
    cyc = 0;
    div[0] = 4; div[1] = 1;
    for (int m = 0; m < 2; m++) begin
      viol[m] = 0; pcs[m] = 1'b1; psck[m] = 1'b0; pmosi[m] = 1'b0;
      sh[m] = 16'h0; nbits[m] = 0; last_rise[m] = 0; hi_run[m] = 100;
    end
    forever begin
      @(negedge clk);
      cyc++;
      for (int m = 0; m < 2; m++) begin
        c = (m == 0) ? cs_a : cs_b;
        s = (m == 0) ? sck_a : sck_b;
        d = (m == 0) ? mosi_a : mosi_b;
        if (rst) begin
          nbits[m] = 0; sh[m] = 16'h0; pcs[m] = 1'b1; psck[m] = 1'b0;
          pmosi[m] = 1'b0; hi_run[m] = 100;
        end else begin
          if (c && s) viol[m]++;
          if (s && !psck[m]) begin
            if (d !== pmosi[m]) viol[m]++;
            if (nbits[m] > 0 && (cyc - last_rise[m]) != 2 * div[m]) viol[m]++;
            last_rise[m] = cyc;
            sh[m] = {sh[m][14:0], d};
            nbits[m]++;
          end else if (s && psck[m] && d !== pmosi[m]) begin
            viol[m]++;
          end
          if (c && !pcs[m]) begin
            if (nbits[m] == 16) begin
              if (m == 0) words_a.push_back(sh[m]);
              else        words_b.push_back(sh[m]);
            end else begin
              viol[m]++;
            end
            nbits[m] = 0;
            hi_run[m] = 0;
          end
          if (c) hi_run[m]++;
          if (!c && pcs[m] && hi_run[m] < div[m]) viol[m]++;
          pcs[m] = c; psck[m] = s; pmosi[m] = d;
        end
      end
    end
  end

  // Pulse frame on one instance and wait (bounded) for frame_done.
  task automatic run_frame(input int which, output int busy_cnt, output int done_cnt);
    busy_cnt = 0;
    done_cnt = 0;
    @(negedge clk);
    if (which == 0) frame_a = 1'b1; else frame_b = 1'b1;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      frame_a = 1'b0;
      frame_b = 1'b0;
      if ((which == 0) ? busy_a : busy_b) busy_cnt++;
      if ((which == 0) ? done_a : done_b) begin
        done_cnt++;
        break;
      end
    end
    repeat (40) begin
      @(negedge clk);
      if ((which == 0) ? done_a : done_b) done_cnt++;
    end
  endtask

  task automatic compare_words(input string tag, input int which, input int base);
    int n;
    logic [15:0] w;
    n = (which == 0) ? words_a.size() - base : words_b.size() - base;
    check_value({tag, "_nwords"}, n, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < n) w = (which == 0) ? words_a[base+i] : words_b[base+i];
      else       w = 16'hDEAD;
      check_value($sformatf("%s_w%0d", tag, i), {16'h0, w}, {16'h0, exp_q[i]});
    end
  endtask

  initial begin
    int bc, dc, base;
    rst = 1'b1;
    frame_a = 1'b0; frame_b = 1'b0;
    bright_a = 4'h0; bright_b = 4'h0;
    cells_a = 64'h0; cells_b = 32'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_value("rst_cs",   cs_a,   1);
    check_value("rst_sck",  sck_a,  0);
    check_value("rst_mosi", mosi_a, 0);
    check_value("rst_busy", busy_a, 0);
    check_value("rst_done", done_a, 0);

    // Test 1: first frame, all cells off, brightness 3.
    bright_a = 4'h3;
    exp_q = '{16'h0C01, 16'h0B07, 16'h0900, 16'h0F00, 16'h0A03,
              16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0500, 16'h0600, 16'h0700, 16'h0800};
    base = words_a.size();
    run_frame(0, bc, dc);
    check_value("t1_busy_cycles", bc, 1716);
    check_value("t1_done_pulses", dc, 1);
    compare_words("t1", 0, base);
    $display("t1 first frame busy=%0d done=%0d words=%0d", bc, dc, words_a.size() - base);

    // Test 2: cells (0,0) and (7,7), brightness F, no config words.
    cells_a = 64'h8000_0000_0000_0001;
    bright_a = 4'hF;
    exp_q = '{16'h0A0F, 16'h0180, 16'h0200, 16'h0300, 16'h0400,
              16'h0500, 16'h0600, 16'h0700, 16'h0801};
    base = words_a.size();
    run_frame(0, bc, dc);
    check_value("t2_busy_cycles", bc, 1188);
    check_value("t2_done_pulses", dc, 1);
    compare_words("t2", 0, base);
    $display("t2 second frame busy=%0d done=%0d", bc, dc);

    // Test 3: frame held high throughout, inputs changed mid-frame.
    base = words_a.size();
    bc = 0; dc = 0;
    @(negedge clk);
    cells_a = 64'h0123_4567_89AB_CDEF;
    bright_a = 4'h5;
    frame_a = 1'b1;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (i == 10)  begin cells_a = ~cells_a; bright_a = 4'h9; end
      if (i == 600) cells_a = 64'hFFFF_0000_FFFF_0000;
      if (busy_a) bc++;
      if (done_a) begin dc++; break; end
    end
    frame_a = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (busy_a || done_a) dc++;
    end
    exp_q = '{16'h0A05, 16'h01F7, 16'h02B3, 16'h03D5, 16'h0491,
              16'h05E6, 16'h06A2, 16'h07C4, 16'h0880};
    check_value("t3_busy_cycles", bc, 1188);
    check_value("t3_single_frame", dc, 1);
    compare_words("t3", 0, base);
    $display("t3 held frame busy=%0d done_or_rebusy=%0d", bc, dc);

    // Test 4: reset during bit 9 of row 3 (word 4 of a configured frame).
    cells_a = 64'hFFFF_FFFF_FFFF_FFFF;
    bright_a = 4'h2;
    @(negedge clk);
    frame_a = 1'b1;
    @(negedge clk);
    frame_a = 1'b0;
    repeat (578) @(negedge clk);
    check_value("t4_pre_cs", cs_a, 0);
    check_value("t4_pre_busy", busy_a, 1);
    #2 rst = 1'b1;
    #1;
    check_value("t4_rst_cs",   cs_a,   1);
    check_value("t4_rst_sck",  sck_a,  0);
    check_value("t4_rst_mosi", mosi_a, 0);
    check_value("t4_rst_busy", busy_a, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    cells_a = 64'h0;
    bright_a = 4'h1;
    exp_q = '{16'h0C01, 16'h0B07, 16'h0900, 16'h0F00, 16'h0A01,
              16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0500, 16'h0600, 16'h0700, 16'h0800};
    base = words_a.size();
    run_frame(0, bc, dc);
    check_value("t4_busy_cycles", bc, 1716);
    compare_words("t4", 0, base);
    $display("t4 reset mid-word then frame busy=%0d", bc);

    // Test 5: CLK_DIV=1, HEIGHT=4 instance.
    cells_b = 32'h8040_2001;
    bright_b = 4'h7;
    exp_q = '{16'h0C01, 16'h0B03, 16'h0900, 16'h0F00, 16'h0A07,
              16'h0180, 16'h0204, 16'h0302, 16'h0401};
    base = words_b.size();
    run_frame(1, bc, dc);
    check_value("t5_busy_cycles", bc, 297);
    check_value("t5_done_pulses", dc, 1);
    compare_words("t5", 1, base);
    $display("t5 small instance busy=%0d done=%0d", bc, dc);

    check_value("proto_a", viol[0], 0);
    check_value("proto_b", viol[1], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
